// File: rtl/uart_instr_loader.sv
`timescale 1ns/1ps
// Boot loader: parses a length-prefixed UART frame into little-endian words written to imem, holding the CPU until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_instr_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ack,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    WORD  = 3'd2,
    WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CSUM  = 3'd4,
`endif
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FINAL = CSUM;
`else
  localparam state_t FINAL = DONE;
`endif

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic              valid_d1;
  logic              ack_q;
  logic [7:0]        cnt_lo;
  logic [16:0]       words_left;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [TO_W-1:0]   to_cnt;
  logic              take;
  logic              to_state;
  logic              timeout;
  logic [16:0]       cnt_new;

  // One accept per rising edge of the valid level; terminal states swallow everything.
  assign take    = rx_data_valid & ~valid_d1 & (state_q != DONE) & (state_q != ERR);
  assign cnt_new = {1'b0, rx_data, cnt_lo};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign to_state = (state_q == HDR1) | (state_q == WORD) | (state_q == CSUM);
`else
  assign to_state = (state_q == HDR1) | (state_q == WORD);
`endif

  assign timeout = (TIMEOUT_CYCLES != 0) && to_state && !take && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HDR0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = HDR0;
    end else begin
      case (state_q)
        HDR0:  if (take) state_d = HDR1;
        HDR1:  if (take) begin
                 if (cnt_new > CAP)       state_d = ERR;
                 else if (cnt_new == '0)  state_d = FINAL;
                 else                     state_d = WORD;
               end
        WORD:  if (take && byte_idx == 2'd3) state_d = WRITE;
        WRITE: state_d = (words_left == 17'd1) ? FINAL : WORD;
`ifdef LOADER_CHECKSUM_EN
        CSUM:  if (take) state_d = ((csum ^ rx_data) == 8'h00) ? DONE : ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d1   <= 1'b0;
      ack_q      <= 1'b0;
      cnt_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      wdata      <= '0;
      to_cnt     <= '0;
    end else begin
      valid_d1 <= rx_data_valid;
      ack_q    <= take;
      // WRITE is a single cycle inside a frame, so it neither advances nor clears the idle timer.
      if (take || timeout)   to_cnt <= '0;
      else if (to_state)     to_cnt <= to_cnt + 1'b1;
      else if (state_q != WRITE) to_cnt <= '0;

      if (timeout) begin
        byte_idx <= '0;
        addr     <= '0;
      end else begin
        case (state_q)
          HDR0: if (take) cnt_lo <= rx_data;
          HDR1: if (take) words_left <= cnt_new;
          WORD: if (take) begin
                  wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                  byte_idx <= byte_idx + 2'd1;
                end
          WRITE: begin
                   words_left <= words_left - 17'd1;
                   // Stop on the last word so a full-capacity image never wraps the address.
                   if (words_left != 17'd1) addr <= addr + 1'b1;
                 end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          csum <= '0;
    else if (timeout) csum <= '0;
    else if (take)    csum <= csum ^ rx_data;
  end
`endif

  assign rx_ack     = ack_q;
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr;
  assign imem_wdata = wdata;
  assign cpu_hold   = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign load_err   = (state_q == ERR);

endmodule

// File: tb/tb_uart_instr_loader.sv
`timescale 1ns/1ps
// Directed + randomized frames checked against a frame-level model of the expected writes, acks and final status.
module tb_uart_instr_loader;

  localparam int ADDR_W = 4;
  localparam int CAPW   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_data_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ack;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  uart_instr_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .rx_ack(rx_ack), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int wide_cnt = 0;
  logic we_prev = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] frame_w[0:CAPW-1];

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        wa_q.push_back(32'(imem_addr));
        wd_q.push_back(imem_wdata);
      end
      if (rx_ack) ack_cnt++;
      if (imem_we && we_prev) wide_cnt++;
      we_prev = imem_we;
    end else begin
      we_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rx_data_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_obs();
    wa_q.delete();
    wd_q.delete();
    ack_cnt = 0;
    wide_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk);
    #1 rx_data = b;
    rx_data_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_data_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Builds the frame for frame_w[0:cnt-1], sends it and checks the outcome predicted from the frame rules.
  task automatic load_and_check(input string tag, input int cnt, input bit bad_csum);
    logic [7:0] bq[$];
    logic [7:0] x;
    logic [31:0] w;
    bit ok;
    int exp_writes;
    int exp_acks;
    clear_obs();
    bq.push_back(cnt[7:0]);
    bq.push_back(cnt[15:8]);
    if (cnt <= CAPW) begin
      for (int i = 0; i < cnt; i++) begin
        w = frame_w[i];
        for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
      end
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (bq[i]) x = x ^ bq[i];
      if (bad_csum) x = x ^ 8'h5A;
      bq.push_back(x);
`endif
    end else begin
      for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    end
    foreach (bq[i]) send_byte(bq[i], 1 + (i % 3));
    repeat (5) @(posedge clk);

    ok = (cnt <= CAPW) && !bad_csum;
    exp_writes = (cnt <= CAPW) ? cnt : 0;
    exp_acks   = (cnt <= CAPW) ? bq.size() : 2;
    chk({tag, ".nwrites"}, 32'(wa_q.size()), 32'(exp_writes));
    for (int i = 0; i < exp_writes; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), (i < wa_q.size()) ? wa_q[i] : 32'hxxxxxxxx, 32'(i));
      chk($sformatf("%s.data%0d", tag, i), (i < wd_q.size()) ? wd_q[i] : 32'hxxxxxxxx, frame_w[i]);
    end
    chk({tag, ".acks"}, 32'(ack_cnt), 32'(exp_acks));
    chk({tag, ".we_width"}, 32'(wide_cnt), 32'd0);
    chk({tag, ".done"}, 32'(load_done), 32'(ok));
    chk({tag, ".err"}, 32'(load_err), 32'(!ok));
    chk({tag, ".hold"}, 32'(cpu_hold), 32'(!ok));
  endtask

  initial begin
    int n;
    int exp_bytes;
    // Reset state
    #2;
    chk("rst.hold", 32'(cpu_hold), 32'd1);
    chk("rst.done", 32'(load_done), 32'd0);
    chk("rst.err", 32'(load_err), 32'd0);
    chk("rst.we", 32'(imem_we), 32'd0);
    chk("rst.ack", 32'(rx_ack), 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk("rst.wdata", imem_wdata, 32'd0);
    do_reset();

    // Single known instruction
    frame_w[0] = 32'h00100513;
    load_and_check("one", 1, 1'b0);

    // Three words, sequential addresses
    do_reset();
    frame_w[0] = 32'h11111111; frame_w[1] = 32'h22222222; frame_w[2] = 32'h33333333;
    load_and_check("three", 3, 1'b0);

    // Level held for 50 cycles yields a single accept
    do_reset();
    clear_obs();
    send_byte(8'h01, 50);
    chk("hold50.acks", 32'(ack_cnt), 32'd1);
    send_byte(8'h00, 1);
    send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 1);
    exp_bytes = 7;
`else
    exp_bytes = 6;
`endif
    repeat (4) @(posedge clk);
    chk("hold50.total_acks", 32'(ack_cnt), 32'(exp_bytes));
    chk("hold50.data", (wd_q.size() > 0) ? wd_q[0] : 32'hxxxxxxxx, 32'hDEADBEEF);
    chk("hold50.done", 32'(load_done), 32'd1);

    // Oversized count rejected after header; trailing bytes ignored
    do_reset();
    load_and_check("oversize", CAPW + 1, 1'b0);

    // Exactly full capacity, and zero count
    do_reset();
    for (int i = 0; i < CAPW; i++) frame_w[i] = $urandom;
    load_and_check("full", CAPW, 1'b0);
    do_reset();
    load_and_check("zero", 0, 1'b0);

    // Mid-frame timeout returns to header parsing without error
    do_reset();
    clear_obs();
    send_byte(8'h02, 1); send_byte(8'h00, 1); send_byte(8'hAA, 1);
    repeat (150) @(posedge clk);
    chk("tmo.nwrites", 32'(wa_q.size()), 32'd0);
    chk("tmo.acks", 32'(ack_cnt), 32'd3);
    chk("tmo.err", 32'(load_err), 32'd0);
    chk("tmo.hold", 32'(cpu_hold), 32'd1);
    frame_w[0] = $urandom;
    load_and_check("after_tmo", 1, 1'b0);

    // Async reset in the middle of the second word
    do_reset();
    clear_obs();
    frame_w[0] = 32'hCAFEF00D;
    send_byte(8'h03, 1); send_byte(8'h00, 1);
    send_byte(8'h0D, 1); send_byte(8'hF0, 1); send_byte(8'hFE, 1); send_byte(8'hCA, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 1);
    chk("midrst.prewrites", 32'(wa_q.size()), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst.hold", 32'(cpu_hold), 32'd1);
    chk("midrst.we", 32'(imem_we), 32'd0);
    chk("midrst.addr", 32'(imem_addr), 32'd0);
    chk("midrst.wdata", imem_wdata, 32'd0);
    chk("midrst.flags", {30'd0, load_done, load_err}, 32'd0);
    do_reset();
    frame_w[0] = $urandom;
    load_and_check("after_rst", 1, 1'b0);

    // Randomized frames
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(0, CAPW);
      for (int i = 0; i < n; i++) frame_w[i] = $urandom;
      load_and_check($sformatf("rand%0d", r), n, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    frame_w[0] = $urandom; frame_w[1] = $urandom;
    load_and_check("badcsum", 2, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
